// File: rtl/axi_pkg.sv
// Shared widths, FSM state encoding and command record for the AXI command sequencer.
package axi_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int RESP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/axi_cmd_fifo.sv
// Command FIFO for the sequencer: DEPTH entries (power of two), occupancy count,
// full/empty flags. Push is ignored when full, pop is ignored when empty.
module axi_cmd_fifo
  import axi_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  cmd_t             push_data_i,
  input  logic             pop_i,
  output cmd_t             head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers are exactly PTR_W bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// Queues host read/write commands and issues them one at a time to an AXI master,
// returning one completion per command. Optional WAIT timeout: AXI_CMD_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no command in flight; leave when the FIFO holds an entry
// ST_ISSUE | one-cycle read/write pulse for the FIFO head; head popped on exit
// ST_WAIT  | waiting for the matching R or B handshake (or timeout)
// ST_RESP  | completion held on rsp_* until rsp_ready
module axi_cmd_sequencer
  import axi_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     read,
  output logic                     write,
  output logic [ADDR_W-1:0]        address_to_read,
  output logic [ADDR_W-1:0]        address_to_write,
  output logic [DATA_W-1:0]        data_to_write,
  input  logic                     R_VALID,
  input  logic                     R_READY,
  input  logic [DATA_W-1:0]        data_read,
  input  logic                     B_VALID,
  input  logic                     B_READY,
  input  logic [RESP_W-1:0]        BRESPONSE,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  state_e            state_q, state_d;
  logic              pend_write_q, pend_write_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  cmd_t              head;
  cmd_t              push_cmd;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              in_issue;
  logic              in_resp;

  assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;

  axi_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cmd_valid),
    .push_data_i (push_cmd),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef AXI_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d      = state_q;
    pend_write_d = pend_write_q;
    rsp_write_d  = rsp_write_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    fifo_pop     = 1'b0;
`ifdef AXI_CMD_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        fifo_pop     = 1'b1;
        pend_write_d = head.write;
        state_d      = ST_WAIT;
`ifdef AXI_CMD_TIMEOUT_EN
        tmo_d        = TMO_W'(TIMEOUT_CYC - 1);
`endif
      end
      ST_WAIT: begin
        // Only the handshake matching the pending command type completes it.
        if (pend_write_q && B_VALID && B_READY) begin
          rsp_write_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = (BRESPONSE != '0);
          state_d     = ST_RESP;
        end else if (!pend_write_q && R_VALID && R_READY) begin
          rsp_write_d = 1'b0;
          rsp_data_d  = data_read;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end
`ifdef AXI_CMD_TIMEOUT_EN
        else if (tmo_q == '0) begin
          rsp_write_d = pend_write_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pend_write_q <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_write_q <= pend_write_d;
      rsp_write_q  <= rsp_write_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef AXI_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`endif

  assign in_issue = (state_q == ST_ISSUE);
  assign in_resp  = (state_q == ST_RESP);

  assign read             = in_issue && !head.write;
  assign write            = in_issue &&  head.write;
  assign address_to_read  = read  ? head.addr  : '0;
  assign address_to_write = write ? head.addr  : '0;
  assign data_to_write    = write ? head.wdata : '0;

  assign rsp_valid = in_resp;
  assign rsp_write = in_resp && rsp_write_q;
  assign rsp_data  = in_resp ? rsp_data_q : '0;
  assign rsp_err   = in_resp && rsp_err_q;

endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// Directed bench for axi_cmd_sequencer: table of single-command transactions plus
// hand sequences for reset, full FIFO, backpressure, reset mid-WAIT and timeout.
module tb_axi_cmd_sequencer;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       read, write;
  logic [3:0] address_to_read, address_to_write;
  logic [7:0] data_to_write;
  logic       R_VALID, R_READY;
  logic [7:0] data_read;
  logic       B_VALID, B_READY;
  logic [3:0] BRESPONSE;
  logic       rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [7:0] rsp_data;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  logic [4:0] iss_q[$];

  axi_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .read(read), .write(write),
    .address_to_read(address_to_read), .address_to_write(address_to_write),
    .data_to_write(data_to_write),
    .R_VALID(R_VALID), .R_READY(R_READY), .data_read(data_read),
    .B_VALID(B_VALID), .B_READY(B_READY), .BRESPONSE(BRESPONSE),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every issued request as {is_write, address}.
  always @(negedge clk) begin
    if (rst && (read || write))
      iss_q.push_back({write, write ? address_to_write : address_to_read});
  end

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [3:0] bresp;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    R_VALID = 0; R_READY = 0; data_read = 0;
    B_VALID = 0; B_READY = 0; BRESPONSE = 0;
  endtask

  task automatic push_cmd(input logic wr, input logic [3:0] a, input logic [7:0] d);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
    tick();
    cmd_valid = 0;
  endtask

  initial begin
    vecs[0] = '{wr:0, addr:4'h6, wdata:8'h00, rdata:8'hAA, bresp:4'h0, exp_data:8'hAA, exp_err:0};
    vecs[1] = '{wr:1, addr:4'h6, wdata:8'h55, rdata:8'h00, bresp:4'h0, exp_data:8'h00, exp_err:0};
    vecs[2] = '{wr:0, addr:4'h6, wdata:8'h00, rdata:8'h55, bresp:4'h0, exp_data:8'h55, exp_err:0};
    vecs[3] = '{wr:1, addr:4'h3, wdata:8'h77, rdata:8'h00, bresp:4'h2, exp_data:8'h00, exp_err:1};
    vecs[4] = '{wr:0, addr:4'hF, wdata:8'h00, rdata:8'h00, bresp:4'h0, exp_data:8'h00, exp_err:0};
    vecs[5] = '{wr:1, addr:4'hA, wdata:8'hFF, rdata:8'h3C, bresp:4'h8, exp_data:8'h00, exp_err:1};

    idle_inputs();
    rsp_ready = 0;
    rst = 0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pulses", {read, write}, 0);
    chk("rst_addr_data", {address_to_read, address_to_write, data_to_write}, 0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_data, rsp_err}, 0);
    chk("rst_count", fifo_count, 0);
    rst = 1;
    tick();

    // Table: one command each, pulse timing, wrong-type handshake ignored, response.
    for (int i = 0; i < 6; i++) begin
      push_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk("push_count", fifo_count, 1);
      chk("pre_issue_pulse", {read, write}, 0);
      tick();
      if (vecs[i].wr) begin
        chk("issue_write", {write, read}, 2'b10);
        chk("issue_waddr", address_to_write, vecs[i].addr);
        chk("issue_wdata", data_to_write, vecs[i].wdata);
      end else begin
        chk("issue_read", {read, write}, 2'b10);
        chk("issue_raddr", address_to_read, vecs[i].addr);
      end
      tick();
      chk("wait_pulse", {read, write}, 0);
      chk("wait_outs_zero", {address_to_read, address_to_write, data_to_write}, 0);
      chk("popped_count", fifo_count, 0);
      if (vecs[i].wr) begin R_VALID = 1; R_READY = 1; data_read = 8'hEE; end
      else begin B_VALID = 1; B_READY = 1; BRESPONSE = 4'h3; end
      tick();
      idle_inputs();
      chk("wrong_hs_ignored", rsp_valid, 0);
      if (vecs[i].wr) begin B_VALID = 1; B_READY = 1; BRESPONSE = vecs[i].bresp; end
      else begin R_VALID = 1; R_READY = 1; data_read = vecs[i].rdata; end
      tick();
      idle_inputs();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_write", rsp_write, vecs[i].wr);
      chk("rsp_data", rsp_data, vecs[i].exp_data);
      chk("rsp_err", rsp_err, vecs[i].exp_err);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("rsp_taken", rsp_valid, 0);
    end

    // Handshake while idle must not create a response.
    R_VALID = 1; R_READY = 1; B_VALID = 1; B_READY = 1;
    tick(); tick();
    idle_inputs();
    chk("idle_hs_ignored", {rsp_valid, read, write}, 0);

    // Full FIFO: c0 (read) stalls in WAIT while c1..c4 fill the FIFO.
    iss_q.delete();
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cmd_write = i[0]; cmd_addr = i[3:0]; cmd_wdata = 8'(i + 8'h10); cmd_valid = 1;
      tick();
    end
    chk("full_count", fifo_count, 4);
    chk("full_ready", cmd_ready, 0);
    cmd_write = 1; cmd_addr = 4'h5; cmd_wdata = 8'h15; cmd_valid = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("held_count", fifo_count, 4);
    end
    R_VALID = 1; R_READY = 1; data_read = 8'h99;
    tick();
    R_VALID = 0; R_READY = 0;
    chk("full_rsp_data", rsp_data, 8'h99);
    tick();
    tick();
    chk("full_issue_c1", {write, address_to_write}, 5'h11);
    chk("full_ready_at_pop", cmd_ready, 0);
    tick();
    chk("after_pop_count", fifo_count, 3);
    chk("after_pop_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("c5_pushed_count", fifo_count, 4);
    R_VALID = 1; R_READY = 1; B_VALID = 1; B_READY = 1;
    for (int k = 0; k < 40; k++) tick();
    idle_inputs();
    chk("drain_count", fifo_count, 0);
    chk("drain_rsp", rsp_valid, 0);
    chk("issue_total", iss_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      logic [4:0] e;
      e = {i[0], i[3:0]};
      chk("issue_order", (i < iss_q.size()) ? {27'd0, iss_q[i]} : 32'hFFFF_FFFF, {27'd0, e});
    end
    rsp_ready = 0;

    // Error write with backpressure; stray R handshake in RESP is ignored.
    push_cmd(1, 4'h2, 8'h42);
    tick(); tick();
    B_VALID = 1; B_READY = 1; BRESPONSE = 4'h2;
    tick();
    idle_inputs();
    R_VALID = 1; R_READY = 1; data_read = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_fields", {rsp_write, rsp_data, rsp_err}, {1'b1, 8'h00, 1'b1});
      tick();
    end
    idle_inputs();
    chk("bp_still_valid", rsp_valid, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("bp_released", rsp_valid, 0);

    // Reset mid-WAIT discards the pending read and the queued command.
    push_cmd(0, 4'h9, 8'h00);
    tick();
    push_cmd(1, 4'h4, 8'h44);
    chk("pre_rst_count", fifo_count, 1);
    #2 rst = 0;
    #1;
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_rsp", rsp_valid, 0);
    tick();
    rst = 1;
    R_VALID = 1; R_READY = 1; data_read = 8'h77;
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      chk("postrst_quiet", {rsp_valid, read, write}, 0);
      tick();
    end

`ifdef AXI_CMD_TIMEOUT_EN
    push_cmd(0, 4'h1, 8'h00);
    tick(); tick();
    for (int k = 0; k < 63; k++) tick();
    chk("tmo_not_yet", rsp_valid, 0);
    tick();
    chk("tmo_valid", rsp_valid, 1);
    chk("tmo_fields", {rsp_data, rsp_err}, {8'h00, 1'b1});
`else
    push_cmd(0, 4'h1, 8'h00);
    tick(); tick();
    for (int k = 0; k < 100; k++) tick();
    chk("no_tmo", rsp_valid, 0);
    R_VALID = 1; R_READY = 1; data_read = 8'h81;
    tick();
    idle_inputs();
    chk("late_rsp", {rsp_valid, rsp_data, rsp_err}, {1'b1, 8'h81, 1'b0});
`endif
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("final_idle", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
